// File: rtl/lpm_pack_pkg.sv
// Shared helpers for the LPM packer family: derived counter width.
package lpm_pack_pkg;

  // Ceiling log2 with a floor of 1 so a counter port never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lpm_pack.sv
// Serial-to-parallel word packer: gathers lpm_size words into one registered
// vector with valid/ready on both sides and a single output holding register.
module lpm_pack
  import lpm_pack_pkg::*;
#(
  parameter lpm_type = "lpm_pack",
  parameter int lpm_width = 1,
  parameter int lpm_size = 1,
  parameter lpm_hint = "UNUSED",
  localparam int CNT_W = clog2_min1(lpm_size)
) (
  input  logic                          clock,
  input  logic                          aclr_n,
  input  logic                          sclr,
  input  logic [lpm_width-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [lpm_size*lpm_width-1:0] data,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [CNT_W-1:0]              count
);

  logic [lpm_size*lpm_width-1:0] fill;
  logic [lpm_size*lpm_width-1:0] vec;
  logic                          last;
  logic                          accept;
  logic                          xfer;

  assign last      = (count == CNT_W'(lpm_size - 1));
  // Only the completing word has to wait for the output register to drain.
  assign din_ready = !(last && data_valid && !data_ready);
  assign accept    = din_valid && din_ready;
  assign xfer      = data_valid && data_ready;

  // The top lane of fill is never needed: the completing word comes straight from din.
  always_comb begin
    vec = fill;
    vec[(lpm_size-1)*lpm_width +: lpm_width] = din;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      count      <= '0;
      fill       <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else if (sclr) begin
      count      <= '0;
      fill       <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int j = 0; j < lpm_size; j++) begin
          if (CNT_W'(j) == count) fill[j*lpm_width +: lpm_width] <= din;
        end
        count <= last ? '0 : count + CNT_W'(1);
      end
      // A load in the same edge as a transfer keeps data_valid high.
      if (accept && last) begin
        data       <= vec;
        data_valid <= 1'b1;
      end else if (xfer) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
